alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-port arbiter that time-shares the single core ALU between the execute stage (requester 0) and the branch/address helper (requester 1). Each requester issues opcode/operand/tag transactions over a valid/ready handshake. The arbiter drives the ALU combinationally from the granted request and registers the ALU outputs into a one-entry response slot per requester. Total throughput is one ALU operation per cycle, with no bubbles when response slots drain.

## Interface
- TAG_W, 4, width of the transaction tag echoed back with each response
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (grant)
- req0_op / req1_op  in  t_alu_opcode  ALU operation selector
- req0_a, req0_b / req1_a, req1_b  in  32  ALU operands in_1, in_2
- req0_tag / req1_tag  in  TAG_W  transaction tag
- rsp0_valid / rsp1_valid  out  1  response slot full
- rsp0_ready / rsp1_ready  in  1  consumer takes response
- rsp0_res / rsp1_res  out  32  captured arith_res
- rsp0_ovf / rsp1_ovf  out  1  captured arith_ovf
- rsp0_cmp / rsp1_cmp  out  1  captured comp_res
- rsp0_tag / rsp1_tag  out  TAG_W  tag of the captured request
- alu_sel  out  t_alu_opcode  to ALU selector
- alu_in_1, alu_in_2  out  32  to ALU operands
- alu_arith_res  in  32  from ALU
- alu_arith_ovf, alu_comp_res  in  1  from ALU

## Operation
- Eligibility of requester i:
  - reqi_valid is high, and
  - either rspi_valid is 0, or rspi_valid & rspi_ready (slot draining this cycle).
- Arbitration when both requesters are eligible: round-robin pointer rr_last (1 bit, reset value 1).
  - The requester ≠ rr_last is granted.
  - rr_last is updated to the granted index on every grant.
  - rr_last is not updated on idle cycles.
- Single eligible requester: it is granted regardless of the pointer.
- reqi_ready = grant_i. At most one grant per cycle. ready is a combinational function of valid and slot state, and has no combinational path from rsp*_ready other than the drain term.
- ALU drive:
  - When a grant is issued, alu_sel/alu_in_1/alu_in_2 = the granted request's op/a/b.
  - With no grant, alu_sel = alu_nop1 and alu_in_1 = alu_in_2 = 0 (operand gating).
- Capture: on a grant, at the clock edge rspi_res/ovf/cmp/tag are loaded from the ALU outputs and reqi_tag, and rspi_valid is set to 1.
- Drain: rspi_valid & rspi_ready with no new grant to i clears rspi_valid. Data fields hold their last value.
- Simultaneous drain and grant on the same requester: the slot is overwritten and rspi_valid stays 1.
- Unsupported opcodes pass through unchanged. The ALU defaults apply (res = 0, cmp = 0).
- Reset mid-operation: all slots are cleared and any in-flight result is discarded. Requesters must reissue.

## Timing
- Reset values:
  - rsp*_valid = 0, rsp*_res = 0, rsp*_ovf = 0, rsp*_cmp = 0, rsp*_tag = 0, rr_last = 1.
  - req*_ready and alu_* are combinational. They are 0 / nop1 / 0 while no request is valid.
- Latency: a request accepted at edge T produces rsp valid from T+1. Data is stable until the cycle after the rsp handshake.
- Back-to-back: with rspi_ready held high, requester i alone sustains 1 op/cycle.
- Both requesters continuously valid with ready consumers: strict alternation 0,1,0,1…
- A full, stalled slot blocks only its own requester. The other requester gets every cycle.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins when both are eligible, and rr_last is unused (held at reset value).
  - Undefined (default): round-robin as above.
  - Eligibility and slot rules are identical in both modes.

## Test plan
- Reset, then req0 add a=32'h7FFF_FFFF b=1 tag=3 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, res=32'h8000_0000, ovf=0, tag=3.
- Both valid every cycle, ops sub 5-7 (req0) and sltu 5<7 (req1), rsp ready high -> grants 0,1,0,1; rsp0_res=32'hFFFF_FFFE, ovf=1; rsp1_cmp=1.
- rsp0_ready=0 with rsp0 full, req0 and req1 valid -> req0_ready=0, req1 granted every cycle. Raise rsp0_ready -> req0 granted in that same cycle, slot overwritten, rsp0_valid remains 1.
- Idle cycle, no valid -> alu_sel=alu_nop1, alu_in_1=alu_in_2=0, no slot or rr_last change.
- Assert rst_n=0 while rsp1_valid=1 -> rsp1_valid=0 immediately (asynchronous), res=0. After release, first contention goes to requester 0.
- ALU_ARB_FIXED_PRIO_EN defined, both valid for 4 cycles with ready consumers -> requester 0 granted all 4 cycles, req1_ready=0 throughout.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter time-sharing one ALU, with a registered one-entry response slot per requester.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention (default: round-robin).
package alu_arb_pkg;
  typedef enum logic [3:0] {
    alu_nop1 = 4'd0,
    alu_add  = 4'd1,
    alu_sub  = 4'd2,
    alu_and  = 4'd3,
    alu_or   = 4'd4,
    alu_xor  = 4'd5,
    alu_slt  = 4'd6,
    alu_sltu = 4'd7,
    alu_nop2 = 4'd15
  } t_alu_opcode;
endpackage

module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  t_alu_opcode       req0_op,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  t_alu_opcode       req1_op,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [31:0]       rsp0_res,
  output logic              rsp0_ovf,
  output logic              rsp0_cmp,
  output logic [TAG_W-1:0]  rsp0_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [31:0]       rsp1_res,
  output logic              rsp1_ovf,
  output logic              rsp1_cmp,
  output logic [TAG_W-1:0]  rsp1_tag,
  output t_alu_opcode       alu_sel,
  output logic [31:0]       alu_in_1,
  output logic [31:0]       alu_in_2,
  input  logic [31:0]       alu_arith_res,
  input  logic              alu_arith_ovf,
  input  logic              alu_comp_res
);

  logic elig0, elig1, grant0, grant1;
  logic rr_last;

  // A slot that drains this cycle can accept a new result at the same edge.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

  // rr_last == 1 favours requester 0; in fixed-priority builds it never leaves 1.
  assign grant0 = elig0 & (~elig1 | rr_last);
  assign grant1 = elig1 & ~grant0;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_sel  = alu_nop1;
    alu_in_1 = '0;
    alu_in_2 = '0;
    if (grant0) begin
      alu_sel  = req0_op;
      alu_in_1 = req0_a;
      alu_in_2 = req0_b;
    end else if (grant1) begin
      alu_sel  = req1_op;
      alu_in_1 = req1_a;
      alu_in_2 = req1_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      rr_last <= 1'b1;
`else
      if (grant0)
        rr_last <= 1'b0;
      else if (grant1)
        rr_last <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp0_ovf   <= 1'b0;
      rsp0_cmp   <= 1'b0;
      rsp0_tag   <= '0;
    end else if (grant0) begin
      rsp0_valid <= 1'b1;
      rsp0_res   <= alu_arith_res;
      rsp0_ovf   <= alu_arith_ovf;
      rsp0_cmp   <= alu_comp_res;
      rsp0_tag   <= req0_tag;
    end else if (rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid <= 1'b0;
      rsp1_res   <= '0;
      rsp1_ovf   <= 1'b0;
      rsp1_cmp   <= 1'b0;
      rsp1_tag   <= '0;
    end else if (grant1) begin
      rsp1_valid <= 1'b1;
      rsp1_res   <= alu_arith_res;
      rsp1_ovf   <= alu_arith_ovf;
      rsp1_cmp   <= alu_comp_res;
      rsp1_tag   <= req1_tag;
    end else if (rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed steps then random traffic against a slot/arbitration model.
// Honours ALU_ARB_FIXED_PRIO_EN in its model when the design is built with it.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid [2];
  logic              req_ready [2];
  t_alu_opcode       req_op    [2];
  logic [31:0]       req_a     [2];
  logic [31:0]       req_b     [2];
  logic [TAG_W-1:0]  req_tag   [2];
  logic              rsp_valid [2];
  logic              rsp_ready [2];
  logic [31:0]       rsp_res   [2];
  logic              rsp_ovf   [2];
  logic              rsp_cmp   [2];
  logic [TAG_W-1:0]  rsp_tag   [2];
  t_alu_opcode       alu_sel;
  logic [31:0]       alu_in_1, alu_in_2, alu_arith_res;
  logic              alu_arith_ovf, alu_comp_res;

  alu_share_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_tag(req_tag[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_tag(req_tag[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_res(rsp_res[0]),
    .rsp0_ovf(rsp_ovf[0]), .rsp0_cmp(rsp_cmp[0]), .rsp0_tag(rsp_tag[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_res(rsp_res[1]),
    .rsp1_ovf(rsp_ovf[1]), .rsp1_cmp(rsp_cmp[1]), .rsp1_tag(rsp_tag[1]),
    .alu_sel(alu_sel), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_arith_res(alu_arith_res), .alu_arith_ovf(alu_arith_ovf), .alu_comp_res(alu_comp_res)
  );

  // Behavioural ALU: carry/borrow as ovf, compares on cmp, unsupported ops give zeros.
  function automatic logic [33:0] alu_ref(input t_alu_opcode op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic ovf, cmp;
    logic [32:0] wide;
    res = '0; ovf = 1'b0; cmp = 1'b0;
    case (op)
      alu_add:  begin wide = {1'b0, a} + {1'b0, b}; res = wide[31:0]; ovf = wide[32]; end
      alu_sub:  begin res = a - b; ovf = (a < b); end
      alu_and:  res = a & b;
      alu_or:   res = a | b;
      alu_xor:  res = a ^ b;
      alu_slt:  cmp = ($signed(a) < $signed(b));
      alu_sltu: cmp = (a < b);
      default:  ;
    endcase
    return {ovf, cmp, res};
  endfunction

  logic [33:0] alu_out;
  always_comb alu_out = alu_ref(alu_sel, alu_in_1, alu_in_2);
  assign alu_arith_res = alu_out[31:0];
  assign alu_comp_res  = alu_out[32];
  assign alu_arith_ovf = alu_out[33];

  bit               m_valid [2];
  logic [31:0]      m_res   [2];
  bit               m_ovf   [2];
  bit               m_cmp   [2];
  logic [TAG_W-1:0] m_tag   [2];
  int               m_last;
  int               last_g;
  int               n_cmp = 0;
  int               n_err = 0;

  t_alu_opcode ops [9] = '{alu_nop1, alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_slt, alu_sltu, alu_nop2};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_res[i] = '0; m_ovf[i] = 0; m_cmp[i] = 0; m_tag[i] = '0;
    end
    m_last = 1;
  endtask

  task automatic chk_rsp();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rsp%0d_valid", i), rsp_valid[i], m_valid[i]);
      chk($sformatf("rsp%0d_res", i),   rsp_res[i],   m_res[i]);
      chk($sformatf("rsp%0d_ovf", i),   rsp_ovf[i],   m_ovf[i]);
      chk($sformatf("rsp%0d_cmp", i),   rsp_cmp[i],   m_cmp[i]);
      chk($sformatf("rsp%0d_tag", i),   rsp_tag[i],   m_tag[i]);
    end
  endtask

  task automatic set_req(input int i, input logic v, input t_alu_opcode op,
                         input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_valid[i] = v; req_op[i] = op; req_a[i] = a; req_b[i] = b; req_tag[i] = tag;
  endtask

  // One clock: called just after a falling edge with inputs already applied.
  task automatic cycle();
    bit e [2];
    int g;
    logic [33:0] r;
    #1;
    for (int i = 0; i < 2; i++) e[i] = req_valid[i] && (!m_valid[i] || rsp_ready[i]);
    g = -1;
    if (e[0] && e[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = 1 - m_last;
`endif
    end else if (e[0]) g = 0;
    else if (e[1]) g = 1;
    chk("req0_ready", req_ready[0], g == 0);
    chk("req1_ready", req_ready[1], g == 1);
    chk("alu_sel",  alu_sel,  (g >= 0) ? req_op[g] : alu_nop1);
    chk("alu_in_1", alu_in_1, (g >= 0) ? req_a[g]  : 32'd0);
    chk("alu_in_2", alu_in_2, (g >= 0) ? req_b[g]  : 32'd0);
    r = (g >= 0) ? alu_ref(req_op[g], req_a[g], req_b[g]) : '0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin
        m_valid[i] = 1; m_res[i] = r[31:0]; m_cmp[i] = r[32]; m_ovf[i] = r[33]; m_tag[i] = req_tag[g];
      end else if (m_valid[i] && rsp_ready[i]) begin
        m_valid[i] = 0;
      end
    end
    if (g >= 0) m_last = g;
    last_g = g;
    #1;
    chk_rsp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, alu_nop1, '0, '0, '0);
      rsp_ready[i] = 1'b0;
    end
    model_reset();
    last_g = -1;
    repeat (2) @(negedge clk);
    chk_rsp();
    rst_n = 1'b1;
    @(negedge clk);

    // Single add with tag
    set_req(0, 1'b1, alu_add, 32'h7FFF_FFFF, 32'd1, 4'd3);
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
    cycle();
    chk("t1_grant", last_g, 0);
    chk("t1_valid", rsp_valid[0], 1'b1);
    chk("t1_res", rsp_res[0], 32'h8000_0000);
    chk("t1_ovf", rsp_ovf[0], 1'b0);
    chk("t1_tag", rsp_tag[0], 4'd3);
    req_valid[0] = 1'b0;
    cycle();
    chk("t1_drain", rsp_valid[0], 1'b0);

    // Contention with both consumers ready
    set_req(0, 1'b1, alu_sub, 32'd5, 32'd7, 4'd1);
    set_req(1, 1'b1, alu_sltu, 32'd5, 32'd7, 4'd2);
    for (int k = 0; k < 6; k++) begin
      cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("fixed_grant", last_g, 0);
`else
      chk("alt_grant", last_g, (k + 1) % 2);
`endif
    end
    chk("alt_res0", rsp_res[0], 32'hFFFF_FFFE);
    chk("alt_ovf0", rsp_ovf[0], 1'b1);
`ifndef ALU_ARB_FIXED_PRIO_EN
    chk("alt_cmp1", rsp_cmp[1], 1'b1);
`endif

    // Stalled slot 0 blocks only requester 0
    rsp_ready[0] = 1'b0;
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, alu_add, 32'd10, 32'd20, 4'd5);
    cycle();
    chk("stall_fill", rsp_valid[0], 1'b1);
    set_req(1, 1'b1, alu_xor, 32'hF0F0_0000, 32'h0FF0_1234, 4'd6);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("stall_grant1", last_g, 1);
    end
    rsp_ready[0] = 1'b1;
    set_req(0, 1'b1, alu_or, 32'h0000_1000, 32'h0000_0001, 4'd9);
    cycle();
    chk("unstall_grant0", last_g, 0);
    chk("unstall_valid", rsp_valid[0], 1'b1);
    chk("unstall_res", rsp_res[0], 32'h0000_1001);
    chk("unstall_tag", rsp_tag[0], 4'd9);

    // Idle cycles: ALU gated, slots hold
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
    repeat (2) cycle();
    chk("idle_sel", alu_sel, alu_nop1);

    // Asynchronous reset with slot 1 full
    set_req(1, 1'b1, alu_and, 32'hFFFF_0000, 32'h1234_5678, 4'd7);
    cycle();
    chk("rst_pre_valid", rsp_valid[1], 1'b1);
    req_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", rsp_valid[1], 1'b0);
    chk("rst_async_res", rsp_res[1], 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, alu_slt, 32'hFFFF_FFFF, 32'd1, 4'd2);
    set_req(1, 1'b1, alu_add, 32'd1, 32'd2, 4'd4);
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
    cycle();
    chk("post_rst_grant", last_g, 0);
    chk("post_rst_cmp", rsp_cmp[0], 1'b1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        set_req(i, ($urandom_range(3) != 0), ops[$urandom_range(8)],
                ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom(),
                4'($urandom_range(15)));
        rsp_ready[i] = ($urandom_range(2) != 0);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
